gps_gga_status_decoder: RTL and testbench
=========================================

// Module: gps_gga_status_decoder
// PURPOSE
//  Parses the NMEA byte stream from the PmodGPS UART receiver and derives the
//  gps_active / fix / approx qualifiers that drive the system state machine.
//  Validates each GGA sentence by checksum, maps its fix-quality field to
//  fix/approx, and expires stale status by timeout. Sits between uart_rx and systemsm.
// PARAMETERS
//  CLK_HZ     12_000_000  core clock frequency in Hz
//  ACTIVE_MS  2000        no-byte window after which gps_active_o drops
//  STALE_MS   3000        no-valid-GGA window after which fix_o/approx_o clear
//  MAX_LEN    82          max chars '$'..checksum; longer sentence is aborted
// PORTS
//  clk_i          in   1  core clock, rising edge
//  reset_i        in   1  reset, asynchronous, active-low
//  rx_data_i      in   8  received ASCII byte
//  rx_valid_i     in   1  one-cycle strobe: rx_data_i is valid this cycle
//  gps_active_o   out  1  a byte was received within ACTIVE_MS
//  fix_o          out  1  last valid GGA quality '1' or '2', not stale
//  approx_o       out  1  last valid GGA quality '6' (estimated), not stale
//  sentence_ok_o  out  1  one-cycle pulse: valid GGA committed
//  cksum_err_o    out  1  one-cycle pulse: GGA rejected (checksum/format/length)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in HUNT, timers expired, checksum acc 0.
//  - Bytes are consumed only on cycles with rx_valid_i=1; there is no backpressure.
//  - FSM states: HUNT, HDR, FIELDS, CK_HI, CK_LO, SKIP.
//   HUNT: wait for '$' -> HDR, clear XOR acc, len=0, hdr idx=0.
//   HDR: 5 chars XORed into acc; chars 3..5 must be "GGA" (any talker). Fail -> SKIP.
//    After 5 chars, next char must be ',' -> FIELDS with comma count=1; otherwise SKIP.
//   FIELDS: XOR every char; count commas; first char after comma 6 is latched as quality.
//    An empty field 6 latches '0'. '*' (not XORed) -> CK_HI.
//   CK_HI/CK_LO: uppercase hex digits only ('0'-'9','A'-'F'); second digit completes
//    the byte. Match with acc -> commit; mismatch or non-hex -> cksum_err_o, HUNT.
//   SKIP: ignore everything until '$'.
//  - '$' in any state restarts the sentence (-> HDR). If the interrupted sentence was
//    a GGA in FIELDS/CK_*, pulse cksum_err_o.
//  - len counts chars from '$'; exceeding MAX_LEN in HDR/FIELDS/CK_* -> HUNT.
//    Exceeding during a GGA (FIELDS/CK_*) also pulses cksum_err_o.
//  - Commit (registered, 1 cycle after the CK_LO byte): quality '1'/'2' -> fix=1,approx=0;
//    '6' -> fix=0,approx=1; any other -> both 0. sentence_ok_o pulses; stale timer reloads.
//  - fix_o/approx_o are mutually exclusive at all times.
//  - Active timer: reloads to ACTIVE_MS*(CLK_HZ/1000)-1 on any rx_valid_i; gps_active_o=1
//    while nonzero; updates the cycle after the strobe.
//  - Stale timer: reloaded on commit; on reaching 0, fix_o and approx_o clear next cycle.
//  - Simultaneous commit and stale expiry: commit wins. Strobe and active expiry in the
//    same cycle: gps_active_o stays 1.
//  - Timer widths: $clog2(MS*CLK_HZ/1000+1). Counters saturate at 0 and never wrap.
//  - Async reset mid-sentence: immediate return to reset values; no pulse is emitted.
// STRUCTURE
//  - gps_pkg: state enum nmea_state_e, ASCII constants (DOLLAR, STAR, COMMA),
//    fix-quality codes, and function hex_to_nibble() returning {valid, nibble}.
//  - One sub-module, retrigger_timer #(CYCLES): load_i, busy_o.
//    It is instantiated twice: active timer and stale timer.
// TESTING
//  1 Reset, no bytes -> all outputs 0. One byte 'x' -> gps_active_o=1 next cycle.
//    gps_active_o returns to 0 after ACTIVE_MS (use small param override).
//  2 "$GPGGA,...,1,..." with bench-computed correct checksum -> sentence_ok_o pulse,
//    then fix_o=1, approx_o=0.
//  3 Same sentence with quality '6' -> approx_o=1, fix_o=0.
//    Then quality '0' -> both 0.
//  4 Valid quality-1 GGA with checksum digit flipped -> cksum_err_o pulse; fix_o unchanged.
//    A lowercase hex digit is also rejected.
//  5 "$GPRMC,...": no pulses, no change. "$GPGGA,12" then "$GPGGA..." valid
//    -> cksum_err_o for the first, then commit for the second.
//  6 fix_o=1, then silence for STALE_MS -> fix_o=0. Commit landing on the expiry cycle
//    keeps fix_o=1. reset_i low mid-sentence -> outputs 0, no pulse.

Source files
------------

// File: rtl/gps_gga_status_decoder_pkg.sv
// rtl/gps_gga_status_decoder_pkg.sv - NMEA GGA decoder types, ASCII constants and hex helper
package gps_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR,
        ST_FIELDS,
        ST_CK_HI,
        ST_CK_LO,
        ST_SKIP
    } nmea_state_e;

    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] STAR   = 8'h2A;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] CHAR_G = 8'h47;
    localparam logic [7:0] CHAR_A = 8'h41;

    // GGA fix-quality field characters
    localparam logic [7:0] Q_INVALID = 8'h30;
    localparam logic [7:0] Q_GPS     = 8'h31;
    localparam logic [7:0] Q_DGPS    = 8'h32;
    localparam logic [7:0] Q_EST     = 8'h36;

    // Uppercase hex only; returns {valid, nibble}
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            return {1'b1, c[3:0] + 4'd9};
        end else begin
            return 5'd0;
        end
    endfunction

endpackage

// File: rtl/gps_gga_status_decoder_if.sv
// rtl/gps_gga_status_decoder_if.sv - byte strobe link from the UART receiver
interface gps_gga_status_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/gps_gga_status_decoder_retrigger_timer.sv
// rtl/gps_gga_status_decoder_retrigger_timer.sv - retriggerable down-counter, busy while nonzero
module retrigger_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic busy_o
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;

    // A load on the expiry cycle wins, so a retrigger never lets busy_o drop
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign busy_o = (r_cnt != '0);

endmodule

// File: rtl/gps_gga_status_decoder.sv
// rtl/gps_gga_status_decoder.sv - GGA sentence parser deriving gps_active/fix/approx status
module gps_gga_status_decoder
    import gps_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int ACTIVE_MS = 2000,
    parameter int STALE_MS  = 3000,
    parameter int MAX_LEN   = 82
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    gps_gga_status_decoder_if.slave    rx,
    output logic                       gps_active_o,
    output logic                       fix_o,
    output logic                       approx_o,
    output logic                       sentence_ok_o,
    output logic                       cksum_err_o
);

    localparam int CYC_PER_MS    = CLK_HZ / 1000;
    localparam int ACTIVE_CYCLES = ACTIVE_MS * CYC_PER_MS;
    localparam int STALE_CYCLES  = STALE_MS * CYC_PER_MS;
    localparam int LEN_W         = $clog2(MAX_LEN + 2);

    nmea_state_e      r_state, w_state_nx;
    logic [7:0]       r_acc, w_acc_nx;
    logic [LEN_W-1:0] r_len, w_len_nx;
    logic [2:0]       r_hdr_idx, w_hdr_idx_nx;
    logic [3:0]       r_commas, w_commas_nx;
    logic [7:0]       r_qual, w_qual_nx;
    logic             r_qual_pend, w_qual_pend_nx;
    logic [3:0]       r_ck_hi, w_ck_hi_nx;

    logic             r_fix, r_approx, r_ok, r_err;
    logic             w_commit, w_err;
    logic             w_stale_busy;
    logic [LEN_W-1:0] w_len_inc;
    logic             w_over;
    logic [4:0]       w_hex;
    logic [7:0]       w_byte;
    logic             w_hdr_ok;

    assign w_byte    = rx.rx_data;
    assign w_len_inc = r_len + LEN_W'(1);
    assign w_over    = (w_len_inc > LEN_W'(MAX_LEN));
    assign w_hex     = hex_to_nibble(w_byte);

    // Talker ID (chars 1..2) is free; chars 3..5 must spell GGA
    always_comb begin
        w_hdr_ok = 1'b1;
        case (r_hdr_idx)
            3'd2, 3'd3: w_hdr_ok = (w_byte == CHAR_G);
            3'd4:       w_hdr_ok = (w_byte == CHAR_A);
            default:    w_hdr_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_HUNT;
            r_acc       <= '0;
            r_len       <= '0;
            r_hdr_idx   <= '0;
            r_commas    <= '0;
            r_qual      <= Q_INVALID;
            r_qual_pend <= 1'b0;
            r_ck_hi     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_len       <= w_len_nx;
            r_hdr_idx   <= w_hdr_idx_nx;
            r_commas    <= w_commas_nx;
            r_qual      <= w_qual_nx;
            r_qual_pend <= w_qual_pend_nx;
            r_ck_hi     <= w_ck_hi_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = r_acc;
        w_len_nx       = r_len;
        w_hdr_idx_nx   = r_hdr_idx;
        w_commas_nx    = r_commas;
        w_qual_nx      = r_qual;
        w_qual_pend_nx = r_qual_pend;
        w_ck_hi_nx     = r_ck_hi;
        w_commit       = 1'b0;
        w_err          = 1'b0;

        if (rx.rx_valid) begin
            if (w_byte == DOLLAR) begin
                // A new '$' always restarts; an interrupted GGA body counts as rejected
                w_err          = (r_state inside {ST_FIELDS, ST_CK_HI, ST_CK_LO});
                w_state_nx     = ST_HDR;
                w_acc_nx       = '0;
                w_len_nx       = LEN_W'(1);
                w_hdr_idx_nx   = '0;
                w_commas_nx    = '0;
                w_qual_nx      = Q_INVALID;
                w_qual_pend_nx = 1'b0;
            end else if ((r_state inside {ST_HDR, ST_FIELDS, ST_CK_HI, ST_CK_LO}) && w_over) begin
                w_state_nx = ST_HUNT;
                w_err      = (r_state != ST_HDR);
            end else begin
                unique case (r_state)
                    ST_HUNT, ST_SKIP: begin
                        w_state_nx = r_state;
                    end
                    ST_HDR: begin
                        w_len_nx = w_len_inc;
                        if (r_hdr_idx == 3'd5) begin
                            if (w_byte == COMMA) begin
                                w_state_nx  = ST_FIELDS;
                                w_acc_nx    = r_acc ^ w_byte;
                                w_commas_nx = 4'd1;
                            end else begin
                                w_state_nx = ST_SKIP;
                            end
                        end else begin
                            w_acc_nx     = r_acc ^ w_byte;
                            w_hdr_idx_nx = r_hdr_idx + 3'd1;
                            if (!w_hdr_ok) begin
                                w_state_nx = ST_SKIP;
                            end
                        end
                    end
                    ST_FIELDS: begin
                        w_len_nx = w_len_inc;
                        if (w_byte == STAR) begin
                            w_state_nx = ST_CK_HI;
                        end else begin
                            w_acc_nx = r_acc ^ w_byte;
                            if (w_byte == COMMA) begin
                                if (r_commas != 4'hF) begin
                                    w_commas_nx = r_commas + 4'd1;
                                end
                                // Quality stays '0' unless field 6 has a first character
                                w_qual_pend_nx = (r_commas == 4'd5);
                            end else if (r_qual_pend) begin
                                w_qual_nx      = w_byte;
                                w_qual_pend_nx = 1'b0;
                            end
                        end
                    end
                    ST_CK_HI: begin
                        w_len_nx = w_len_inc;
                        if (w_hex[4]) begin
                            w_ck_hi_nx = w_hex[3:0];
                            w_state_nx = ST_CK_LO;
                        end else begin
                            w_err      = 1'b1;
                            w_state_nx = ST_HUNT;
                        end
                    end
                    ST_CK_LO: begin
                        w_len_nx   = w_len_inc;
                        w_state_nx = ST_HUNT;
                        if (w_hex[4] && ({r_ck_hi, w_hex[3:0]} == r_acc)) begin
                            w_commit = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nx = ST_HUNT;
                    end
                endcase
            end
        end
    end

    // Commit outranks stale expiry; both qualifiers come from one compare so they stay exclusive
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_fix    <= 1'b0;
            r_approx <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ok  <= w_commit;
            r_err <= w_err;
            if (w_commit) begin
                r_fix    <= (r_qual == Q_GPS) || (r_qual == Q_DGPS);
                r_approx <= (r_qual == Q_EST);
            end else if (!w_stale_busy) begin
                r_fix    <= 1'b0;
                r_approx <= 1'b0;
            end
        end
    end

    retrigger_timer #(.CYCLES(ACTIVE_CYCLES)) u_active_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (rx.rx_valid),
        .busy_o  (gps_active_o)
    );

    retrigger_timer #(.CYCLES(STALE_CYCLES)) u_stale_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (w_commit),
        .busy_o  (w_stale_busy)
    );

    assign fix_o         = r_fix;
    assign approx_o      = r_approx;
    assign sentence_ok_o = r_ok;
    assign cksum_err_o   = r_err;

endmodule

// File: tb/tb_gps_gga_status_decoder.sv
// tb/tb_gps_gga_status_decoder.sv - directed self-checking bench for gps_gga_status_decoder
module tb_gps_gga_status_decoder;

    logic clk = 1'b0;
    logic reset_n;
    logic gps_active, fix, approx, sentence_ok, cksum_err;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ok_cnt   = 0;
    int   err_cnt  = 0;
    int   excl_viol = 0;

    always #5 clk = ~clk;

    gps_gga_status_decoder_if rx_if ();

    gps_gga_status_decoder #(
        .CLK_HZ    (1000),
        .ACTIVE_MS (40),
        .STALE_MS  (150),
        .MAX_LEN   (40)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_n),
        .rx            (rx_if),
        .gps_active_o  (gps_active),
        .fix_o         (fix),
        .approx_o      (approx),
        .sentence_ok_o (sentence_ok),
        .cksum_err_o   (cksum_err)
    );

    always @(posedge clk) begin
        #1;
        if (sentence_ok) ok_cnt++;
        if (cksum_err) err_cnt++;
        if (fix && approx) excl_viol++;
    end

    function automatic byte nibch(input logic [3:0] n);
        return (n < 4'd10) ? byte'(8'h30 + {4'h0, n}) : byte'(8'h37 + {4'h0, n});
    endfunction

    function automatic string hex2(input logic [7:0] v);
        string s;
        s = "00";
        s.putc(0, nibch(v[7:4]));
        s.putc(1, nibch(v[3:0]));
        return s;
    endfunction

    function automatic logic [7:0] xsum(input string body);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < body.len(); i++) cs = cs ^ body[i];
        return cs;
    endfunction

    function automatic string mk(input string body);
        return {"$", body, "*", hex2(xsum(body))};
    endfunction

    function automatic string gga(input string q);
        return {"GPGGA,1,2,3,4,5,", q, ",0"};
    endfunction

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_if.rx_data  = s[i];
            rx_if.rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gps_active, fix, approx, sentence_ok, cksum_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 00000", {gps_active, fix, approx, sentence_ok, cksum_err});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gps_active, fix, approx, sentence_ok, cksum_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 00000", {gps_active, fix, approx, sentence_ok, cksum_err});
        end
    endtask

    task automatic test_active;
        send_str("x");
        n_checks++;
        if (gps_active !== 1'b1) begin
            n_fail++;
            $display("FAIL active_rise: got %b want 1", gps_active);
        end
        repeat (37) @(negedge clk);
        send_str("x");
        n_checks++;
        if (gps_active !== 1'b1) begin
            n_fail++;
            $display("FAIL active_retrigger_at_expiry: got %b want 1", gps_active);
        end
        repeat (38) @(negedge clk);
        n_checks++;
        if (gps_active !== 1'b1) begin
            n_fail++;
            $display("FAIL active_last_cycle: got %b want 1", gps_active);
        end
        @(negedge clk);
        n_checks++;
        if (gps_active !== 1'b0) begin
            n_fail++;
            $display("FAIL active_expire: got %b want 0", gps_active);
        end
        n_checks++;
        if (ok_cnt + err_cnt !== 0) begin
            n_fail++;
            $display("FAIL active_no_pulse: got %0d pulses want 0", ok_cnt + err_cnt);
        end
    endtask

    task automatic test_fix;
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send_str(mk(gga("1")));
        n_checks++;
        if ({sentence_ok, fix, approx} !== 3'b110) begin
            n_fail++;
            $display("FAIL fix_commit: got ok/fix/approx=%b want 110", {sentence_ok, fix, approx});
        end
        @(negedge clk);
        n_checks++;
        if (sentence_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL ok_one_cycle: got %b want 0", sentence_ok);
        end
        n_checks++;
        if ((ok_cnt - ok0) !== 1 || (err_cnt - err0) !== 0) begin
            n_fail++;
            $display("FAIL fix_counts: got ok=%0d err=%0d want 1 0", ok_cnt - ok0, err_cnt - err0);
        end
    endtask

    task automatic test_approx;
        int ok0;
        ok0 = ok_cnt;
        send_str(mk(gga("6")));
        n_checks++;
        if ({fix, approx} !== 2'b01) begin
            n_fail++;
            $display("FAIL approx_q6: got fix/approx=%b want 01", {fix, approx});
        end
        send_str(mk(gga("0")));
        n_checks++;
        if ({fix, approx} !== 2'b00) begin
            n_fail++;
            $display("FAIL quality0: got fix/approx=%b want 00", {fix, approx});
        end
        send_str(mk(gga("2")));
        send_str(mk(gga("")));
        n_checks++;
        if ({fix, approx} !== 2'b00) begin
            n_fail++;
            $display("FAIL quality_empty: got fix/approx=%b want 00", {fix, approx});
        end
        n_checks++;
        if ((ok_cnt - ok0) !== 4) begin
            n_fail++;
            $display("FAIL approx_counts: got ok=%0d want 4", ok_cnt - ok0);
        end
    endtask

    task automatic test_bad_cksum;
        int ok0, err0;
        string s;
        send_str(mk(gga("1")));
        ok0 = ok_cnt; err0 = err_cnt;
        send_str({"$", gga("1"), "*", hex2(xsum(gga("1")) ^ 8'h01)});
        n_checks++;
        if ({cksum_err, sentence_ok, fix} !== 3'b101) begin
            n_fail++;
            $display("FAIL cksum_flip: got err/ok/fix=%b want 101", {cksum_err, sentence_ok, fix});
        end
        s = mk(gga("1"));
        for (int i = s.len() - 2; i < s.len(); i++) begin
            if (s[i] >= 8'h41 && s[i] <= 8'h46) s.putc(i, s[i] + 8'h20);
        end
        send_str(s);
        n_checks++;
        if ({cksum_err, sentence_ok, fix} !== 3'b101) begin
            n_fail++;
            $display("FAIL cksum_lowercase: got err/ok/fix=%b want 101", {cksum_err, sentence_ok, fix});
        end
        n_checks++;
        if ((ok_cnt - ok0) !== 0 || (err_cnt - err0) !== 2) begin
            n_fail++;
            $display("FAIL bad_counts: got ok=%0d err=%0d want 0 2", ok_cnt - ok0, err_cnt - err0);
        end
    endtask

    task automatic test_back_to_back;
        int ok0, err0;
        send_str(mk(gga("1")));
        ok0 = ok_cnt; err0 = err_cnt;
        send_str(mk("GPRMC,1,2,3"));
        n_checks++;
        if ((ok_cnt - ok0) !== 0 || (err_cnt - err0) !== 0 || {fix, approx} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmc_ignored: got ok=%0d err=%0d fix/approx=%b want 0 0 10",
                     ok_cnt - ok0, err_cnt - err0, {fix, approx});
        end
        send_str("$GPGGA,12");
        send_str(mk(gga("6")));
        n_checks++;
        if ((ok_cnt - ok0) !== 1 || (err_cnt - err0) !== 1 || {fix, approx} !== 2'b01) begin
            n_fail++;
            $display("FAIL truncated_then_valid: got ok=%0d err=%0d fix/approx=%b want 1 1 01",
                     ok_cnt - ok0, err_cnt - err0, {fix, approx});
        end
    endtask

    task automatic test_stale;
        string s;
        s = mk(gga("1"));
        send_str(s);
        repeat (149) @(negedge clk);
        n_checks++;
        if (fix !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_before: got %b want 1", fix);
        end
        @(negedge clk);
        n_checks++;
        if (fix !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_expire: got %b want 0", fix);
        end
        send_str(s);
        repeat (149 - s.len()) @(negedge clk);
        send_str(s);
        n_checks++;
        if ({sentence_ok, fix} !== 2'b11) begin
            n_fail++;
            $display("FAIL commit_on_expiry: got ok/fix=%b want 11", {sentence_ok, fix});
        end
    endtask

    task automatic test_length;
        string body;
        int ok0, err0;
        body = gga("1");
        for (int i = 0; i < 17; i++) body = {body, "9"};
        ok0 = ok_cnt; err0 = err_cnt;
        send_str(mk(body));
        n_checks++;
        if ({sentence_ok, cksum_err, fix} !== 3'b101) begin
            n_fail++;
            $display("FAIL len_max_ok: got ok/err/fix=%b want 101", {sentence_ok, cksum_err, fix});
        end
        body = {body, "9"};
        send_str(mk(body));
        n_checks++;
        if ({sentence_ok, cksum_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL len_over: got ok/err=%b want 01", {sentence_ok, cksum_err});
        end
        n_checks++;
        if ((ok_cnt - ok0) !== 1 || (err_cnt - err0) !== 1) begin
            n_fail++;
            $display("FAIL len_counts: got ok=%0d err=%0d want 1 1", ok_cnt - ok0, err_cnt - err0);
        end
    endtask

    task automatic test_reset_mid;
        string s;
        int ok0, err0;
        s = mk(gga("6"));
        send_str(s);
        ok0 = ok_cnt; err0 = err_cnt;
        send_str(s.substr(0, 12));
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({gps_active, fix, approx, sentence_ok, cksum_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 00000", {gps_active, fix, approx, sentence_ok, cksum_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_str(s.substr(13, s.len() - 1));
        repeat (2) @(negedge clk);
        n_checks++;
        if ((ok_cnt - ok0) !== 0 || (err_cnt - err0) !== 0 || {fix, approx} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_no_pulse: got ok=%0d err=%0d fix/approx=%b want 0 0 00",
                     ok_cnt - ok0, err_cnt - err0, {fix, approx});
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        test_reset();
        test_active();
        test_fix();
        test_approx();
        test_bad_cksum();
        test_back_to_back();
        test_stale();
        test_length();
        test_reset_mid();
        n_checks++;
        if (excl_viol !== 0) begin
            n_fail++;
            $display("FAIL fix_approx_exclusive: got %0d overlap cycles want 0", excl_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
